// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier: P = Q*M (+ R when MULT_ADDEND_EN is defined).
// One multiplier bit per clock, fixed WIDTH-cycle latency, single-cycle done pulse.
module shift_add_mult #(
   parameter int WIDTH = 1025
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     Q,
   input  logic [WIDTH-1:0]     M,
`ifdef MULT_ADDEND_EN
   input  logic [WIDTH-1:0]     R,
`endif
   output logic [2*WIDTH-1:0]   P,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]       state;
   logic [WIDTH:0]   hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] mreg;
   logic [CW-1:0]    count;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   hi_nxt;
   logic [WIDTH-1:0] lo_nxt;
   logic [WIDTH:0]   hi_init;

   // Preloading hi with the addend lets it ride down through the WIDTH shifts,
   // so it lands in the low word unscaled: result = Q*M + R.
`ifdef MULT_ADDEND_EN
   assign hi_init = {1'b0, R};
`else
   assign hi_init = '0;
`endif

   always_comb begin
      sum            = hi + (lo[0] ? {1'b0, mreg} : '0);
      {hi_nxt, lo_nxt} = {sum, lo} >> 1;
   end

   assign busy = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         hi    <= '0;
         lo    <= '0;
         mreg  <= '0;
         count <= '0;
         P     <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mreg  <= M;
                  lo    <= Q;
                  hi    <= hi_init;
                  count <= CW'(WIDTH);
                  state <= RUN;
               end
            end
            RUN: begin
               hi    <= hi_nxt;
               lo    <= lo_nxt;
               count <= count - CW'(1);
               // hi never exceeds WIDTH bits after a shift, so dropping its top bit is lossless
               if (count == CW'(1)) begin
                  P     <= {hi_nxt[WIDTH-1:0], lo_nxt};
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
